// File: rtl/servant_mux_n.sv
// servant_mux_n
//   Routes serv dbus Wishbone requests to one of NUM_SLAVES slave ports. The
//   slave is chosen by the top SEL_BITS bits of the master address. The
//   selected slave's response is registered before it returns to the CPU.
//   If the decoded index is NUM_SLAVES or higher, the access completes with
//   ack+err and zero read data. No slave cycle is started in that case.
//
// Optional feature
//   SERVANT_MUX_TIMEOUT_EN : when defined, a slave that stays in BUSY for
//   TIMEOUT cycles without acking is abandoned. The access then completes
//   with ack+err and zero read data. When undefined, BUSY waits indefinitely.
//
// Ports
//   i_wb_clk, i_wb_rstn      clock; asynchronous active-low reset
//   i_wb_cpu_adr/dat/sel/we  master request fields
//   i_wb_cpu_cyc             master request, held until ack/err
//   o_wb_cpu_rdt             registered read data
//   o_wb_cpu_ack             one-cycle completion strobe
//   o_wb_cpu_err             one-cycle error strobe, only together with ack
//   o_wb_s_adr/dat/sel/we    combinational broadcast of the master fields
//   o_wb_s_cyc               one-hot slave cycle (NUM_SLAVES bits)
//   i_wb_s_rdt               flattened slave read data, slave k at [32k+31:32k]
//   i_wb_s_ack               slave acks; only the selected slave's ack is used
module servant_mux_n #(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_BITS   = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                    i_wb_clk,
  input  logic                    i_wb_rstn,
  input  logic [31:0]             i_wb_cpu_adr,
  input  logic [31:0]             i_wb_cpu_dat,
  input  logic [3:0]              i_wb_cpu_sel,
  input  logic                    i_wb_cpu_we,
  input  logic                    i_wb_cpu_cyc,
  output logic [31:0]             o_wb_cpu_rdt,
  output logic                    o_wb_cpu_ack,
  output logic                    o_wb_cpu_err,
  output logic [31:0]             o_wb_s_adr,
  output logic [31:0]             o_wb_s_dat,
  output logic [3:0]              o_wb_s_sel,
  output logic                    o_wb_s_we,
  output logic [NUM_SLAVES-1:0]   o_wb_s_cyc,
  input  logic [32*NUM_SLAVES-1:0] i_wb_s_rdt,
  input  logic [NUM_SLAVES-1:0]   i_wb_s_ack
);

  localparam int IW = $clog2(NUM_SLAVES);

  if (NUM_SLAVES < 2 || NUM_SLAVES > 8 || SEL_BITS < 1 || SEL_BITS > 32 ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("servant_mux_n: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t               r_state, w_state_nxt;
  logic [IW-1:0]        r_idx, w_idx_nxt;
  logic                 r_err, w_err_nxt;
  logic [31:0]          r_rdt, w_rdt_nxt;
  logic [SEL_BITS-1:0]  w_sel;
  logic                 w_mapped;
  logic                 w_ack;
  logic [31:0]          w_slave_rdt;
  logic [NUM_SLAVES-1:0] w_onehot;

  assign w_sel       = i_wb_cpu_adr[31 -: SEL_BITS];
  assign w_mapped    = ({{(32-SEL_BITS){1'b0}}, w_sel} < 32'(NUM_SLAVES));
  assign w_ack       = i_wb_s_ack[r_idx];
  assign w_slave_rdt = i_wb_s_rdt[32*r_idx +: 32];
  assign w_onehot    = {{(NUM_SLAVES-1){1'b0}}, 1'b1} << r_idx;

`ifdef SERVANT_MUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_timeout;
  // The counter value TIMEOUT-1 means that this BUSY cycle is the TIMEOUT-th
  // cycle without an ack, so the slave is given up at the end of it.
  assign w_timeout = (r_cnt == CW'(TIMEOUT-1));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;
    w_rdt_nxt   = r_rdt;
`ifdef SERVANT_MUX_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_wb_cpu_cyc) begin
          if (w_mapped) begin
            w_state_nxt = S_BUSY;
            w_idx_nxt   = IW'(w_sel);
            w_err_nxt   = 1'b0;
`ifdef SERVANT_MUX_TIMEOUT_EN
            w_cnt_nxt   = '0;
`endif
          end else begin
            w_state_nxt = S_RESP;
            w_err_nxt   = 1'b1;
            w_rdt_nxt   = '0;
          end
        end
      end
      S_BUSY: begin
        // A master abort wins over a slave ack in the same cycle.
        if (!i_wb_cpu_cyc) begin
          w_state_nxt = S_IDLE;
        end else if (w_ack) begin
          w_state_nxt = S_RESP;
          w_err_nxt   = 1'b0;
          w_rdt_nxt   = w_slave_rdt;
`ifdef SERVANT_MUX_TIMEOUT_EN
        end else if (w_timeout) begin
          w_state_nxt = S_RESP;
          w_err_nxt   = 1'b1;
          w_rdt_nxt   = '0;
          w_cnt_nxt   = CW'(TIMEOUT);
        end else if (r_cnt != CW'(TIMEOUT)) begin
          w_cnt_nxt   = r_cnt + 1'b1;
`endif
        end
      end
      // The master's trailing cyc is ignored here so that it cannot re-issue.
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rstn) begin
    if (!i_wb_rstn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_rdt   <= '0;
`ifdef SERVANT_MUX_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_err   <= w_err_nxt;
      r_rdt   <= w_rdt_nxt;
`ifdef SERVANT_MUX_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
`endif
    end
  end

  assign o_wb_s_adr   = i_wb_cpu_adr;
  assign o_wb_s_dat   = i_wb_cpu_dat;
  assign o_wb_s_sel   = i_wb_cpu_sel;
  assign o_wb_s_we    = i_wb_cpu_we;
  assign o_wb_s_cyc   = (r_state == S_BUSY) ? w_onehot : '0;
  assign o_wb_cpu_ack = (r_state == S_RESP);
  assign o_wb_cpu_err = (r_state == S_RESP) & r_err;
  assign o_wb_cpu_rdt = r_rdt;

endmodule

// File: tb/tb_servant_mux_n.sv
module tb_servant_mux_n;

  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [31:0]   cpu_adr = '0, cpu_dat = '0;
  logic [3:0]    cpu_sel = '0;
  logic          cpu_we = 1'b0, cpu_cyc = 1'b0;
  logic [31:0]   cpu_rdt;
  logic          cpu_ack, cpu_err;
  logic [31:0]   s_adr, s_dat;
  logic [3:0]    s_sel;
  logic          s_we;
  logic [NS-1:0] s_cyc;
  logic [32*NS-1:0] s_rdt = '0;
  logic [NS-1:0] s_ack = '0;

  typedef struct packed { logic err; logic [31:0] rdt; } resp_t;
  resp_t sb[$];
  resp_t e;

  int n_vec = 0;
  int n_miss = 0;

  servant_mux_n #(.NUM_SLAVES(NS), .SEL_BITS(3), .TIMEOUT(4)) dut (
    .i_wb_clk(clk), .i_wb_rstn(rstn),
    .i_wb_cpu_adr(cpu_adr), .i_wb_cpu_dat(cpu_dat), .i_wb_cpu_sel(cpu_sel),
    .i_wb_cpu_we(cpu_we), .i_wb_cpu_cyc(cpu_cyc),
    .o_wb_cpu_rdt(cpu_rdt), .o_wb_cpu_ack(cpu_ack), .o_wb_cpu_err(cpu_err),
    .o_wb_s_adr(s_adr), .o_wb_s_dat(s_dat), .o_wb_s_sel(s_sel), .o_wb_s_we(s_we),
    .o_wb_s_cyc(s_cyc), .i_wb_s_rdt(s_rdt), .i_wb_s_ack(s_ack)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cpu_adr = 32'hA5A5_0F0F; cpu_dat = 32'h1234_5678; cpu_sel = 4'b1010; cpu_we = 1'b1;
    repeat (2) tick;
    n_vec++; if (s_cyc !== 4'b0000) begin n_miss++; $display("FAIL reset_s_cyc: got %b want 0000", s_cyc); end
    n_vec++; if (cpu_ack !== 1'b0) begin n_miss++; $display("FAIL reset_ack: got %b want 0", cpu_ack); end
    n_vec++; if (cpu_err !== 1'b0) begin n_miss++; $display("FAIL reset_err: got %b want 0", cpu_err); end
    n_vec++; if (cpu_rdt !== 32'h0) begin n_miss++; $display("FAIL reset_rdt: got %h want 0", cpu_rdt); end
    n_vec++; if ({s_adr, s_dat, s_sel, s_we} !== {32'hA5A5_0F0F, 32'h1234_5678, 4'b1010, 1'b1}) begin
      n_miss++; $display("FAIL broadcast: got %h %h %b %b want a5a50f0f 12345678 1010 1", s_adr, s_dat, s_sel, s_we);
    end
    cpu_we = 1'b0;
    @(negedge clk) rstn = 1'b1;
    tick;
    n_vec++; if ({s_cyc, cpu_ack} !== 5'b0) begin n_miss++; $display("FAIL post_reset_idle: got cyc=%b ack=%b want 0", s_cyc, cpu_ack); end
  endtask

  task automatic test_mapped_read;
    cpu_adr = 32'h4000_0010; cpu_cyc = 1'b1;
    n_vec++; if ({s_cyc, cpu_ack} !== 5'b0) begin n_miss++; $display("FAIL rd_c0: got cyc=%b ack=%b want 0", s_cyc, cpu_ack); end
    tick;
    n_vec++; if (s_cyc !== 4'b0100) begin n_miss++; $display("FAIL rd_c1_s_cyc: got %b want 0100", s_cyc); end
    n_vec++; if (cpu_ack !== 1'b0) begin n_miss++; $display("FAIL rd_c1_ack: got %b want 0", cpu_ack); end
    s_ack = 4'b0100; s_rdt[64 +: 32] = 32'hDEAD_BEEF;
    sb.push_back('{err: 1'b0, rdt: 32'hDEAD_BEEF});
    tick;
    s_ack = '0; s_rdt = '0;
    n_vec++; if (s_cyc !== 4'b0000) begin n_miss++; $display("FAIL rd_c2_s_cyc: got %b want 0000", s_cyc); end
    n_vec++;
    if (cpu_ack !== 1'b1 || sb.size() == 0) begin n_miss++; $display("FAIL rd_c2_ack: got %b want 1", cpu_ack); end
    else begin
      e = sb.pop_front();
      n_vec++; if ({cpu_err, cpu_rdt} !== {e.err, e.rdt}) begin
        n_miss++; $display("FAIL rd_resp: got err=%b rdt=%h want err=%b rdt=%h", cpu_err, cpu_rdt, e.err, e.rdt);
      end
    end
    cpu_cyc = 1'b0;
    tick;
    n_vec++; if (cpu_ack !== 1'b0) begin n_miss++; $display("FAIL rd_c3_ack: got %b want 0", cpu_ack); end
  endtask

  task automatic test_reset_busy;
    cpu_adr = 32'h0000_0000; cpu_cyc = 1'b1;
    tick;
    n_vec++; if (s_cyc !== 4'b0001) begin n_miss++; $display("FAIL rb_s_cyc: got %b want 0001", s_cyc); end
    rstn = 1'b0;
    #1;
    n_vec++; if ({s_cyc, cpu_ack, cpu_err, cpu_rdt} !== 38'h0) begin
      n_miss++; $display("FAIL rb_async: got cyc=%b ack=%b err=%b rdt=%h want all 0", s_cyc, cpu_ack, cpu_err, cpu_rdt);
    end
    cpu_cyc = 1'b0;
    @(negedge clk) rstn = 1'b1;
    repeat (2) begin
      tick;
      n_vec++; if ({s_cyc, cpu_ack} !== 5'b0) begin n_miss++; $display("FAIL rb_idle: got cyc=%b ack=%b want 0", s_cyc, cpu_ack); end
    end
  endtask

  task automatic test_back_to_back;
    cpu_adr = 32'h0000_0004; cpu_cyc = 1'b1;
    tick;
    n_vec++; if (s_cyc !== 4'b0001) begin n_miss++; $display("FAIL b2b_a_s_cyc: got %b want 0001", s_cyc); end
    s_ack = 4'b0001; s_rdt[0 +: 32] = 32'h1111_1111;
    sb.push_back('{err: 1'b0, rdt: 32'h1111_1111});
    tick;
    s_ack = '0; s_rdt = '0;
    n_vec++;
    if (cpu_ack !== 1'b1 || sb.size() == 0) begin n_miss++; $display("FAIL b2b_a_ack: got %b want 1", cpu_ack); end
    else begin
      e = sb.pop_front();
      n_vec++; if ({cpu_err, cpu_rdt} !== {e.err, e.rdt}) begin
        n_miss++; $display("FAIL b2b_a_resp: got err=%b rdt=%h want err=%b rdt=%h", cpu_err, cpu_rdt, e.err, e.rdt);
      end
    end
    cpu_adr = 32'h2000_0008;
    tick;
    n_vec++; if ({s_cyc, cpu_ack} !== 5'b0) begin n_miss++; $display("FAIL b2b_gap: got cyc=%b ack=%b want 0", s_cyc, cpu_ack); end
    tick;
    n_vec++; if (s_cyc !== 4'b0010) begin n_miss++; $display("FAIL b2b_b_s_cyc: got %b want 0010", s_cyc); end
    s_ack = 4'b0010; s_rdt[32 +: 32] = 32'h2222_2222;
    sb.push_back('{err: 1'b0, rdt: 32'h2222_2222});
    tick;
    s_ack = '0; s_rdt = '0;
    n_vec++;
    if (cpu_ack !== 1'b1 || sb.size() == 0) begin n_miss++; $display("FAIL b2b_b_ack: got %b want 1", cpu_ack); end
    else begin
      e = sb.pop_front();
      n_vec++; if ({cpu_err, cpu_rdt} !== {e.err, e.rdt}) begin
        n_miss++; $display("FAIL b2b_b_resp: got err=%b rdt=%h want err=%b rdt=%h", cpu_err, cpu_rdt, e.err, e.rdt);
      end
    end
    tick;
    cpu_cyc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if ({s_cyc, cpu_ack} !== 5'b0) begin n_miss++; $display("FAIL b2b_no_third[%0d]: got cyc=%b ack=%b want 0", i, s_cyc, cpu_ack); end
      tick;
    end
  endtask

  task automatic test_unmapped;
    cpu_adr = 32'hE000_0000; cpu_dat = 32'hCAFE_F00D; cpu_sel = 4'b1111; cpu_we = 1'b1; cpu_cyc = 1'b1;
    #1;
    n_vec++; if ({s_adr, s_dat, s_sel, s_we} !== {32'hE000_0000, 32'hCAFE_F00D, 4'b1111, 1'b1}) begin
      n_miss++; $display("FAIL um_broadcast: got %h %h %b %b want e0000000 cafef00d 1111 1", s_adr, s_dat, s_sel, s_we);
    end
    sb.push_back('{err: 1'b1, rdt: 32'h0});
    tick;
    n_vec++; if (s_cyc !== 4'b0000) begin n_miss++; $display("FAIL um_s_cyc: got %b want 0000", s_cyc); end
    n_vec++;
    if (cpu_ack !== 1'b1 || sb.size() == 0) begin n_miss++; $display("FAIL um_ack: got %b want 1", cpu_ack); end
    else begin
      e = sb.pop_front();
      n_vec++; if ({cpu_err, cpu_rdt} !== {e.err, e.rdt}) begin
        n_miss++; $display("FAIL um_resp: got err=%b rdt=%h want err=%b rdt=%h", cpu_err, cpu_rdt, e.err, e.rdt);
      end
    end
    cpu_cyc = 1'b0; cpu_we = 1'b0;
    tick;
    n_vec++; if ({cpu_ack, cpu_err, s_cyc} !== 6'b0) begin n_miss++; $display("FAIL um_after: got ack=%b err=%b cyc=%b want 0", cpu_ack, cpu_err, s_cyc); end
  endtask

  task automatic test_ignore_abort;
    cpu_adr = 32'h6000_0000; cpu_cyc = 1'b1;
    tick;
    n_vec++; if (s_cyc !== 4'b1000) begin n_miss++; $display("FAIL ia_s_cyc: got %b want 1000", s_cyc); end
    s_ack = 4'b0001; s_rdt[0 +: 32] = 32'hBAD0_BAD0;
    tick;
    s_ack = '0; s_rdt = '0;
    n_vec++; if ({cpu_ack, s_cyc} !== 5'b0_1000) begin n_miss++; $display("FAIL ia_wrong_ack: got ack=%b cyc=%b want 0 1000", cpu_ack, s_cyc); end
    cpu_cyc = 1'b0;
    tick;
    n_vec++; if ({cpu_ack, s_cyc} !== 5'b0) begin n_miss++; $display("FAIL ia_abort: got ack=%b cyc=%b want 0", cpu_ack, s_cyc); end
    cpu_cyc = 1'b1;
    tick;
    n_vec++; if (s_cyc !== 4'b1000) begin n_miss++; $display("FAIL ia2_s_cyc: got %b want 1000", s_cyc); end
    cpu_cyc = 1'b0; s_ack = 4'b1000; s_rdt[96 +: 32] = 32'h55AA_55AA;
    tick;
    s_ack = '0; s_rdt = '0;
    n_vec++; if ({cpu_ack, s_cyc, cpu_rdt} !== 37'h0) begin
      n_miss++; $display("FAIL ia2_abort_prio: got ack=%b cyc=%b rdt=%h want 0 0 0", cpu_ack, s_cyc, cpu_rdt);
    end
    tick;
    n_vec++; if (cpu_ack !== 1'b0) begin n_miss++; $display("FAIL ia2_late_ack: got %b want 0", cpu_ack); end
    s_ack = 4'b1111;
    tick;
    s_ack = '0;
    n_vec++; if ({cpu_ack, s_cyc} !== 5'b0) begin n_miss++; $display("FAIL ia_idle_ack: got ack=%b cyc=%b want 0", cpu_ack, s_cyc); end
  endtask

`ifdef SERVANT_MUX_TIMEOUT_EN
  task automatic test_timeout;
    for (int pass = 0; pass < 2; pass++) begin
      cpu_adr = 32'h2000_0000; cpu_cyc = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        tick;
        n_vec++; if ({s_cyc, cpu_ack} !== 5'b0010_0) begin
          n_miss++; $display("FAIL to%0d_busy_c%0d: got cyc=%b ack=%b want 0010 0", pass, c, s_cyc, cpu_ack);
        end
        if (pass == 0 && c == 4) begin
          s_ack = 4'b0010; s_rdt[32 +: 32] = 32'h3333_3333;
        end
      end
      if (pass == 0) sb.push_back('{err: 1'b0, rdt: 32'h3333_3333});
      else           sb.push_back('{err: 1'b1, rdt: 32'h0});
      tick;
      s_ack = '0; s_rdt = '0;
      n_vec++; if (s_cyc !== 4'b0000) begin n_miss++; $display("FAIL to%0d_s_cyc: got %b want 0000", pass, s_cyc); end
      n_vec++;
      if (cpu_ack !== 1'b1 || sb.size() == 0) begin n_miss++; $display("FAIL to%0d_ack: got %b want 1", pass, cpu_ack); end
      else begin
        e = sb.pop_front();
        n_vec++; if ({cpu_err, cpu_rdt} !== {e.err, e.rdt}) begin
          n_miss++; $display("FAIL to%0d_resp: got err=%b rdt=%h want err=%b rdt=%h", pass, cpu_err, cpu_rdt, e.err, e.rdt);
        end
      end
      cpu_cyc = 1'b0;
      tick;
    end
  endtask
`else
  task automatic test_no_timeout;
    cpu_adr = 32'h2000_0000; cpu_cyc = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      n_vec++; if ({s_cyc, cpu_ack, cpu_err} !== 6'b0010_00) begin
        n_miss++; $display("FAIL nto_busy_c%0d: got cyc=%b ack=%b err=%b want 0010 0 0", c, s_cyc, cpu_ack, cpu_err);
      end
    end
    cpu_cyc = 1'b0;
    tick;
    n_vec++; if ({s_cyc, cpu_ack} !== 5'b0) begin n_miss++; $display("FAIL nto_abort: got cyc=%b ack=%b want 0", s_cyc, cpu_ack); end
  endtask
`endif

  initial begin
    test_reset;
    test_mapped_read;
    test_reset_busy;
    test_back_to_back;
    test_unmapped;
    test_ignore_abort;
`ifdef SERVANT_MUX_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    n_vec++; if (sb.size() != 0) begin n_miss++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
